gbp_update_ctrl: RTL and testbench
==================================

GBP_UPDATE_CTRL -- requirements
Module: gbp_update_ctrl

Interface
REQ-001 SHALL have parameters: HIST_W, 12, history/index width; DEPTH, 4, update-queue entries (power of 2).
REQ-002 SHALL have ports (clock and reset first):
- CLK  in  1  clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Fetch_Valid  in  1  branch looked up this cycle.
- Fetch_PC  in  32  branch PC.
- Pred_Taken  in  1  table prediction bit at Lookup_Index.
- Lookup_Index  out  HIST_W  table read index.
- Lookup_Hist  out  HIST_W  GHR used for this lookup, carried down the pipe.
- Res0_Valid / Res1_Valid  in  1  resolved branch, port 0 = older.
- Res0_Ready / Res1_Ready  out  1  port accepted this cycle if Valid.
- ResN_Index  in  HIST_W  index used at lookup.
- ResN_Taken  in  1  actual direction.
- ResN_Mispredict  in  1  direction mispredicted.
- ResN_Hist  in  HIST_W  GHR at lookup.
- Table_Busy  in  1  table cannot take an update this cycle.
- Update  out  1  table write strobe.
- Index  out  HIST_W  table write index.
- Is_Taken  out  1  table update direction.
- Count  out  log2(DEPTH)+1  queue occupancy.

Function
REQ-003 SHALL keep GHR (HIST_W bits) and drive Lookup_Index = Fetch_PC[HIST_W+1:2] XOR GHR, Lookup_Hist = GHR, both combinational.
REQ-004 SHALL, on Fetch_Valid with no accepted mispredict, shift GHR <= {GHR[HIST_W-2:0], Pred_Taken}.
REQ-005 SHALL, on an accepted resolve with Mispredict=1, restore GHR <= {ResN_Hist[HIST_W-2:0], ResN_Taken}.
REQ-006 SHALL, if both ports are accepted with Mispredict=1, restore from port 0.
REQ-007 SHALL give a mispredict restore priority over a same-cycle fetch shift; the fetch shift is dropped.
REQ-008 SHALL compute free = DEPTH - Count from current occupancy only; a same-cycle drain does not create space.
REQ-009 SHALL drive Res0_Ready = (free >= 1).
REQ-010 SHALL drive Res1_Ready = (free >= 2) OR (free >= 1 AND NOT Res0_Valid).
REQ-011 SHALL enqueue {ResN_Index, ResN_Taken} for every accepted resolve, mispredicted or not.
REQ-012 SHALL, when both ports are accepted in one cycle, place port 0's entry ahead of port 1's.
REQ-013 SHALL drive Update = (Count != 0) AND NOT Table_Busy, with Index and Is_Taken taken from the queue head, all combinational.
REQ-014 SHALL pop the head on every cycle Update = 1 (one drain per cycle maximum).
REQ-015 SHALL update Count each cycle as Count + enqueued - popped, range 0..DEPTH.
REQ-016 SHALL wrap the read and write pointers modulo DEPTH.
REQ-017 SHALL never overflow (guaranteed by the Ready rules) and never pop when empty.
REQ-018 SHALL, when full with Table_Busy=0, drain one entry while both Readys stay 0 that cycle.

Reset
REQ-019 SHALL, while RESET=0 (asynchronously), set GHR=0, pointers=0, Count=0, and hence Update=0, Res0_Ready=1, Res1_Ready=1.
REQ-020 SHALL discard all queued entries on reset mid-operation; no Update is issued from pre-reset entries.

Verification
REQ-021 Fetch_Valid=1 for 3 cycles with Pred_Taken=1,0,1 from GHR=0 -> GHR=0x005; with Fetch_PC=0x40 the next Lookup_Index = 0x010 XOR 0x005 = 0x015.
REQ-022 Both ports valid, Count=0: Res0 {0x123, T}, Res1 {0x456, NT} -> both accepted, Count=2; Update strobes 0x123/1 then 0x456/0 in consecutive cycles.
REQ-023 Count=3, DEPTH=4, both valid, Table_Busy=1 -> Res0_Ready=1, Res1_Ready=0, Count=4 next cycle; then both Readys 0 until a drain completes.
REQ-024 Same cycle: Fetch_Valid=1/Pred_Taken=1, Res0 mispredict Hist=0x0F0/Taken=1, Res1 mispredict Hist=0xAAA -> GHR=0x1E1.
REQ-025 Queue holding 3 entries, RESET pulsed low mid-cycle -> Count=0, Update=0 immediately, GHR=0, no stale updates after release.

Source files
------------

// File: rtl/gbp_update_ctrl.sv
// Global-history branch predictor control: speculative GHR with mispredict repair,
// plus a dual-port resolve queue that drains one table update per cycle.
module gbp_update_ctrl #(
  parameter int HIST_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         Fetch_Valid,
  input  logic [31:0]                  Fetch_PC,
  input  logic                         Pred_Taken,
  output logic [HIST_W-1:0]            Lookup_Index,
  output logic [HIST_W-1:0]            Lookup_Hist,
  input  logic                         Res0_Valid,
  output logic                         Res0_Ready,
  input  logic [HIST_W-1:0]            Res0_Index,
  input  logic                         Res0_Taken,
  input  logic                         Res0_Mispredict,
  input  logic [HIST_W-1:0]            Res0_Hist,
  input  logic                         Res1_Valid,
  output logic                         Res1_Ready,
  input  logic [HIST_W-1:0]            Res1_Index,
  input  logic                         Res1_Taken,
  input  logic                         Res1_Mispredict,
  input  logic [HIST_W-1:0]            Res1_Hist,
  input  logic                         Table_Busy,
  output logic                         Update,
  output logic [HIST_W-1:0]            Index,
  output logic                         Is_Taken,
  output logic [$clog2(DEPTH):0]       Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [HIST_W-1:0] ghr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_1;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  free;
  logic [HIST_W-1:0] q_index [DEPTH];
  logic              q_taken [DEPTH];
  logic              acc0;
  logic              acc1;
  logic              pop;
  logic              unused_bits;

  function automatic logic [HIST_W-1:0] hist_push(input logic [HIST_W-1:0] h,
                                                  input logic b);
    return {h[HIST_W-2:0], b};
  endfunction

  assign unused_bits = ^{Fetch_PC[31:HIST_W+2], Fetch_PC[1:0],
                         Res0_Hist[HIST_W-1], Res1_Hist[HIST_W-1]};

  assign Lookup_Index = Fetch_PC[HIST_W+1:2] ^ ghr;
  assign Lookup_Hist  = ghr;

  // Space is judged on current occupancy only; a same-cycle drain does not free a slot.
  assign free       = CNT_W'(DEPTH) - count_q;
  assign Res0_Ready = (free >= CNT_W'(1));
  assign Res1_Ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !Res0_Valid);

  assign acc0     = Res0_Valid & Res0_Ready;
  assign acc1     = Res1_Valid & Res1_Ready;
  assign wr_ptr_1 = wr_ptr + PTR_W'(acc0);

  assign pop      = (count_q != '0) & ~Table_Busy;
  assign Update   = pop;
  assign Index    = q_index[rd_ptr];
  assign Is_Taken = q_taken[rd_ptr];
  assign Count    = count_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ghr     <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Older port wins the repair; any repair overrides the speculative fetch shift.
      if (acc0 && Res0_Mispredict)
        ghr <= hist_push(Res0_Hist, Res0_Taken);
      else if (acc1 && Res1_Mispredict)
        ghr <= hist_push(Res1_Hist, Res1_Taken);
      else if (Fetch_Valid)
        ghr <= hist_push(ghr, Pred_Taken);
      rd_ptr  <= rd_ptr + PTR_W'(pop);
      wr_ptr  <= wr_ptr + PTR_W'(acc0) + PTR_W'(acc1);
      count_q <= count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (acc0) begin
      q_index[wr_ptr] <= Res0_Index;
      q_taken[wr_ptr] <= Res0_Taken;
    end
    if (acc1) begin
      q_index[wr_ptr_1] <= Res1_Index;
      q_taken[wr_ptr_1] <= Res1_Taken;
    end
  end

endmodule

// File: tb/tb_gbp_update_ctrl.sv
// Bench for gbp_update_ctrl: directed vector table, reset-mid-operation sequence,
// then randomized traffic against a queue-based reference model.
module tb_gbp_update_ctrl;

  logic        CLK;
  logic        RESET;
  logic        Fetch_Valid;
  logic [31:0] Fetch_PC;
  logic        Pred_Taken;
  logic [11:0] Lookup_Index;
  logic [11:0] Lookup_Hist;
  logic        Res0_Valid, Res0_Ready, Res0_Taken, Res0_Mispredict;
  logic [11:0] Res0_Index, Res0_Hist;
  logic        Res1_Valid, Res1_Ready, Res1_Taken, Res1_Mispredict;
  logic [11:0] Res1_Index, Res1_Hist;
  logic        Table_Busy;
  logic        Update;
  logic [11:0] Index;
  logic        Is_Taken;
  logic [2:0]  Count;

  int checks;
  int failures;

  gbp_update_ctrl #(.HIST_W(12), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .Fetch_Valid(Fetch_Valid), .Fetch_PC(Fetch_PC), .Pred_Taken(Pred_Taken),
    .Lookup_Index(Lookup_Index), .Lookup_Hist(Lookup_Hist),
    .Res0_Valid(Res0_Valid), .Res0_Ready(Res0_Ready), .Res0_Index(Res0_Index),
    .Res0_Taken(Res0_Taken), .Res0_Mispredict(Res0_Mispredict), .Res0_Hist(Res0_Hist),
    .Res1_Valid(Res1_Valid), .Res1_Ready(Res1_Ready), .Res1_Index(Res1_Index),
    .Res1_Taken(Res1_Taken), .Res1_Mispredict(Res1_Mispredict), .Res1_Hist(Res1_Hist),
    .Table_Busy(Table_Busy), .Update(Update), .Index(Index), .Is_Taken(Is_Taken),
    .Count(Count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        pt;
    logic        r0v;
    logic [11:0] r0i;
    logic        r0t;
    logic        r0m;
    logic [11:0] r0h;
    logic        r1v;
    logic [11:0] r1i;
    logic        r1t;
    logic        r1m;
    logic [11:0] r1h;
    logic        busy;
    logic [11:0] e_lidx;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_upd;
    logic [11:0] e_idx;
    logic        e_tkn;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(int fv, int pc, int pt,
                              int r0v, int r0i, int r0t, int r0m, int r0h,
                              int r1v, int r1i, int r1t, int r1m, int r1h,
                              int busy, int lidx, int rdy0, int rdy1,
                              int upd, int idx, int tkn, int cnt);
    vec_t r;
    r.fv = fv[0];     r.pc = pc;         r.pt = pt[0];
    r.r0v = r0v[0];   r.r0i = r0i[11:0]; r.r0t = r0t[0]; r.r0m = r0m[0]; r.r0h = r0h[11:0];
    r.r1v = r1v[0];   r.r1i = r1i[11:0]; r.r1t = r1t[0]; r.r1m = r1m[0]; r.r1h = r1h[11:0];
    r.busy = busy[0]; r.e_lidx = lidx[11:0];
    r.e_rdy0 = rdy0[0]; r.e_rdy1 = rdy1[0]; r.e_upd = upd[0];
    r.e_idx = idx[11:0]; r.e_tkn = tkn[0]; r.e_cnt = cnt[2:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Fetch_Valid = v.fv;  Fetch_PC = v.pc;  Pred_Taken = v.pt;
    Res0_Valid = v.r0v;  Res0_Index = v.r0i;  Res0_Taken = v.r0t;
    Res0_Mispredict = v.r0m;  Res0_Hist = v.r0h;
    Res1_Valid = v.r1v;  Res1_Index = v.r1i;  Res1_Taken = v.r1t;
    Res1_Mispredict = v.r1m;  Res1_Hist = v.r1h;
    Table_Busy = v.busy;
  endtask

  // Reference model state: history register and an ordered list of pending updates.
  logic [11:0] m_ghr;
  logic [12:0] mq[$];

  initial begin
    vec_t v;
    int   cnt;
    int   fr;
    bit   e_rdy0, e_rdy1, e_upd, a0, a1;

    checks = 0;
    failures = 0;
    RESET = 1'b1;
    drive(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,0,0));
    #2 RESET = 1'b0;
    #1;
    chk("reset count",   32'(Count), 32'd0);
    chk("reset update",  32'(Update), 32'd0);
    chk("reset rdy0",    32'(Res0_Ready), 32'd1);
    chk("reset rdy1",    32'(Res1_Ready), 32'd1);
    chk("reset ghr",     32'(Lookup_Hist), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    // fv, pc, pt | r0 v,i,t,m,h | r1 v,i,t,m,h | busy | lidx, rdy0, rdy1, upd, idx, tkn, cnt
    vt.push_back(mk(1,'h40,1, 0,0,0,0,0,         0,0,0,0,0,          0, 'h010,1,1,0,0,0,0));
    vt.push_back(mk(1,'h40,0, 0,0,0,0,0,         0,0,0,0,0,          0, 'h011,1,1,0,0,0,0));
    vt.push_back(mk(1,'h40,1, 0,0,0,0,0,         0,0,0,0,0,          0, 'h012,1,1,0,0,0,0));
    vt.push_back(mk(0,'h40,0, 1,'h123,1,0,0,     1,'h456,0,0,0,      0, 'h015,1,1,0,0,0,0));
    vt.push_back(mk(0,0,0,    0,0,0,0,0,         0,0,0,0,0,          0, 'h005,1,1,1,'h123,1,2));
    vt.push_back(mk(0,0,0,    0,0,0,0,0,         0,0,0,0,0,          0, 'h005,1,1,1,'h456,0,1));
    vt.push_back(mk(1,0,1,    1,'h0AA,1,1,'h0F0, 1,'h0BB,0,1,'hAAA,  0, 'h005,1,1,0,0,0,0));
    vt.push_back(mk(0,0,0,    0,0,0,0,0,         0,0,0,0,0,          0, 'h1E1,1,1,1,'h0AA,1,2));
    vt.push_back(mk(0,0,0,    0,0,0,0,0,         0,0,0,0,0,          0, 'h1E1,1,1,1,'h0BB,0,1));
    vt.push_back(mk(0,0,0,    1,'h111,1,0,0,     1,'h222,0,0,0,      1, 'h1E1,1,1,0,0,0,0));
    vt.push_back(mk(0,0,0,    1,'h333,1,0,0,     0,0,0,0,0,          1, 'h1E1,1,1,0,0,0,2));
    vt.push_back(mk(0,0,0,    1,'h555,0,0,0,     1,'h666,1,0,0,      1, 'h1E1,1,0,0,0,0,3));
    vt.push_back(mk(0,0,0,    1,'h777,0,0,0,     1,'h666,1,0,0,      1, 'h1E1,0,0,0,0,0,4));
    vt.push_back(mk(0,0,0,    1,'h777,0,0,0,     1,'h666,1,0,0,      0, 'h1E1,0,0,1,'h111,1,4));
    vt.push_back(mk(0,0,0,    0,0,0,0,0,         1,'h666,1,0,0,      0, 'h1E1,1,1,1,'h222,0,3));
    vt.push_back(mk(1,0,0,    0,0,0,0,0,         1,'h0CC,1,1,'h801,  1, 'h1E1,1,1,0,0,0,3));
    vt.push_back(mk(0,'h40,0, 0,0,0,0,0,         0,0,0,0,0,          0, 'h013,0,0,1,'h333,1,4));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLK);
      drive(vt[i]);
      #1;
      chk($sformatf("row%0d lookup_index", i), 32'(Lookup_Index), 32'(vt[i].e_lidx));
      chk($sformatf("row%0d res0_ready", i),   32'(Res0_Ready),   32'(vt[i].e_rdy0));
      chk($sformatf("row%0d res1_ready", i),   32'(Res1_Ready),   32'(vt[i].e_rdy1));
      chk($sformatf("row%0d update", i),       32'(Update),       32'(vt[i].e_upd));
      chk($sformatf("row%0d count", i),        32'(Count),        32'(vt[i].e_cnt));
      if (vt[i].e_upd) begin
        chk($sformatf("row%0d index", i),      32'(Index),        32'(vt[i].e_idx));
        chk($sformatf("row%0d is_taken", i),   32'(Is_Taken),     32'(vt[i].e_tkn));
      end
    end

    // Reset pulsed in the middle of a cycle with three entries still queued.
    @(posedge CLK);
    #2;
    drive(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,0,0));
    #1;
    chk("prereset count", 32'(Count), 32'd3);
    chk("prereset ghr",   32'(Lookup_Hist), 32'h003);
    chk("prereset index", 32'(Index), 32'h555);
    RESET = 1'b0;
    #1;
    chk("midreset count",  32'(Count), 32'd0);
    chk("midreset update", 32'(Update), 32'd0);
    chk("midreset ghr",    32'(Lookup_Hist), 32'd0);
    chk("midreset rdy0",   32'(Res0_Ready), 32'd1);
    chk("midreset rdy1",   32'(Res1_Ready), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("postreset update c%0d", i), 32'(Update), 32'd0);
      chk($sformatf("postreset count c%0d", i),  32'(Count), 32'd0);
    end

    // Randomized traffic against the reference model.
    m_ghr = '0;
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      v = mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,0,0);
      v.fv   = ($urandom_range(0, 3) != 0);
      v.pc   = $urandom;
      v.pt   = $urandom_range(0, 1) == 1;
      v.r0v  = ($urandom_range(0, 9) < 6);
      v.r0i  = 12'($urandom);
      v.r0t  = $urandom_range(0, 1) == 1;
      v.r0m  = ($urandom_range(0, 3) == 0);
      v.r0h  = 12'($urandom);
      v.r1v  = ($urandom_range(0, 9) < 6);
      v.r1i  = 12'($urandom);
      v.r1t  = $urandom_range(0, 1) == 1;
      v.r1m  = ($urandom_range(0, 3) == 0);
      v.r1h  = 12'($urandom);
      v.busy = ($urandom_range(0, 9) < 4);
      drive(v);
      #1;

      cnt    = mq.size();
      fr     = 4 - cnt;
      e_rdy0 = (fr >= 1);
      e_rdy1 = (fr >= 2) || ((fr >= 1) && !v.r0v);
      e_upd  = (cnt != 0) && !v.busy;
      chk($sformatf("rnd%0d lookup_index", c), 32'(Lookup_Index), 32'(v.pc[13:2] ^ m_ghr));
      chk($sformatf("rnd%0d lookup_hist", c),  32'(Lookup_Hist),  32'(m_ghr));
      chk($sformatf("rnd%0d res0_ready", c),   32'(Res0_Ready),   32'(e_rdy0));
      chk($sformatf("rnd%0d res1_ready", c),   32'(Res1_Ready),   32'(e_rdy1));
      chk($sformatf("rnd%0d update", c),       32'(Update),       32'(e_upd));
      chk($sformatf("rnd%0d count", c),        32'(Count),        32'(cnt));
      if (e_upd) begin
        chk($sformatf("rnd%0d index", c),    32'(Index),    32'(mq[0][12:1]));
        chk($sformatf("rnd%0d is_taken", c), 32'(Is_Taken), 32'(mq[0][0]));
      end

      a0 = v.r0v && e_rdy0;
      a1 = v.r1v && e_rdy1;
      if (e_upd) void'(mq.pop_front());
      if (a0) mq.push_back({v.r0i, v.r0t});
      if (a1) mq.push_back({v.r1i, v.r1t});
      if (a0 && v.r0m)      m_ghr = {v.r0h[10:0], v.r0t};
      else if (a1 && v.r1m) m_ghr = {v.r1h[10:0], v.r1t};
      else if (v.fv)        m_ghr = {m_ghr[10:0], v.pt};
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
